// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// hazard_scoreboard_pkg: shared widths, defaults and stall-cause encodings
// for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

   // Each scoreboard entry is {addr[ADDR_W-1:0], tnew[WIDTH_T-1:0]}.
   localparam int ADDR_W          = 5;
   localparam int DEF_WIDTH_T     = 3;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int DEF_CNT_W       = 32;

   localparam logic [DEF_WIDTH_T-1:0] TUSE_INF = '1;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_DATA = 2'b01,
      CAUSE_MD   = 2'b10,
      CAUSE_BOTH = 2'b11
   } stall_cause_e;

   function automatic int md_cnt_w(input int mult_c, input int div_c);
      return $clog2(((mult_c > div_c) ? mult_c : div_c) + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// hazard_scoreboard_if: ID-stage request bundle and stall/scoreboard results.
interface hazard_scoreboard_if
   import hazard_scoreboard_pkg::*;
#(
   parameter int N_STAGES = 2,
   parameter int WIDTH_T  = DEF_WIDTH_T,
   parameter int CNT_W    = DEF_CNT_W
);
   logic                         id_valid;
   logic [ADDR_W-1:0]            id_rs;
   logic [ADDR_W-1:0]            id_rt;
   logic [WIDTH_T-1:0]           id_tuse_rs;
   logic [WIDTH_T-1:0]           id_tuse_rt;
   logic [ADDR_W-1:0]            id_waddr;
   logic [WIDTH_T-1:0]           id_tnew;
   logic                         id_md_use;
   logic                         id_md_start;
   logic                         id_md_div;
   logic                         freeze;
   logic                         flush;

   logic                         stall_pc;
   logic                         stall_id;
   logic                         clr_ex;
   logic [1:0]                   stall_cause;
   logic [ADDR_W*N_STAGES-1:0]   sb_addr_flat;
   logic [WIDTH_T*N_STAGES-1:0]  sb_tnew_flat;
   logic                         md_busy;
   logic [CNT_W-1:0]             stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_waddr, id_tnew,
             id_md_use, id_md_start, id_md_div, freeze, flush,
      input  stall_pc, stall_id, clr_ex, stall_cause, sb_addr_flat, sb_tnew_flat,
             md_busy, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_waddr, id_tnew,
             id_md_use, id_md_start, id_md_div, freeze, flush,
      output stall_pc, stall_id, clr_ex, stall_cause, sb_addr_flat, sb_tnew_flat,
             md_busy, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// hazard_sb_entry: one scoreboard stage holding a pending write address and
// its remaining Tnew, decremented (saturating at 0) as it advances.
module hazard_sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int WIDTH_T = DEF_WIDTH_T
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hold,
   input  logic                clear,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [WIDTH_T-1:0]  d_tnew,
   output logic [ADDR_W-1:0]   addr,
   output logic [WIDTH_T-1:0]  tnew
);

   function automatic logic [WIDTH_T-1:0] sat_dec(input logic [WIDTH_T-1:0] x);
      return (x == '0) ? '0 : x - WIDTH_T'(1);
   endfunction

   // clear outranks hold so a flush lands even while the pipeline is frozen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         tnew <= '0;
      end else if (clear) begin
         addr <= '0;
         tnew <= '0;
      end else if (!hold) begin
         addr <= d_addr;
         tnew <= sat_dec(d_tnew);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// hazard_scoreboard: ID-stage stall generator tracking pending register writes
// over N_STAGES post-ID stages, HI/LO unit busy time and stalled cycles.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int N_STAGES    = 2,
   parameter int WIDTH_T     = DEF_WIDTH_T,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_scoreboard_if.slave   sb
);

   localparam int               MD_W    = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
   localparam logic [MD_W-1:0]  MULT_LD = MD_W'(MULT_CYCLES);
   localparam logic [MD_W-1:0]  DIV_LD  = MD_W'(DIV_CYCLES);

   logic [ADDR_W-1:0]   addr [N_STAGES];
   logic [WIDTH_T-1:0]  tnew [N_STAGES];
   logic [N_STAGES-1:0] hit_rs;
   logic [N_STAGES-1:0] hit_rt;
   logic                data_stall;
   logic                md_stall;
   logic                stall;
   logic                head_valid;
   logic                md_accept;
   logic [MD_W-1:0]     md_cnt;
   logic [CNT_W-1:0]    stall_cnt_q;

   always_comb begin
      hit_rs = '0;
      hit_rt = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         hit_rs[k] = (addr[k] == sb.id_rs) && (tnew[k] > sb.id_tuse_rs);
         hit_rt[k] = (addr[k] == sb.id_rt) && (tnew[k] > sb.id_tuse_rt);
      end
   end

   // $0 is excluded on the source side, so a matching empty entry never stalls
   assign data_stall = sb.id_valid && (((sb.id_rs != '0) && (|hit_rs)) ||
                                       ((sb.id_rt != '0) && (|hit_rt)));
   assign md_stall   = sb.id_valid && sb.id_md_use && (md_cnt != '0);
   assign stall      = data_stall || md_stall;
   assign head_valid = sb.id_valid && !stall;
   assign md_accept  = sb.id_valid && sb.id_md_start && !stall && !sb.freeze && !sb.flush;

   assign sb.stall_pc    = stall;
   assign sb.stall_id    = stall;
   assign sb.clr_ex      = stall;
   assign sb.stall_cause = md_stall ? (data_stall ? CAUSE_BOTH : CAUSE_MD)
                                    : (data_stall ? CAUSE_DATA : CAUSE_NONE);
   assign sb.md_busy     = (md_cnt != '0);
   assign sb.stall_cnt   = stall_cnt_q;

   genvar k;
   generate
      for (k = 0; k < N_STAGES; k++) begin : g_stage
         logic [ADDR_W-1:0]  d_addr;
         logic [WIDTH_T-1:0] d_tnew;

         if (k == 0) begin : g_head
            assign d_addr = head_valid ? sb.id_waddr : '0;
            assign d_tnew = head_valid ? sb.id_tnew  : '0;
         end else begin : g_tail
            assign d_addr = addr[k-1];
            assign d_tnew = tnew[k-1];
         end

         hazard_sb_entry #(.WIDTH_T(WIDTH_T)) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (sb.freeze),
            .clear  (sb.flush),
            .d_addr (d_addr),
            .d_tnew (d_tnew),
            .addr   (addr[k]),
            .tnew   (tnew[k])
         );

         assign sb.sb_addr_flat[ADDR_W*k +: ADDR_W]   = addr[k];
         assign sb.sb_tnew_flat[WIDTH_T*k +: WIDTH_T] = tnew[k];
      end
   endgenerate

   // HI/LO work cannot be cancelled, so neither freeze nor flush touches md_cnt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt <= '0;
      end else if (md_accept) begin
         md_cnt <= sb.id_md_div ? DIV_LD : MULT_LD;
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - MD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall && !sb.freeze) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: cycle-by-cycle vector table plus hand-written reset,
// flush and freeze sequences, checked through an expected-result queue.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [2:0] tuse_rs;
      logic [4:0] rt;
      logic [2:0] tuse_rt;
      logic [4:0] waddr;
      logic [2:0] tnew;
      logic       md_use;
      logic       md_start;
      logic       md_div;
      logic       freeze;
      logic       flush;
   } stim_t;

   typedef struct packed {
      logic        stall;
      logic [1:0]  cause;
      logic        busy;
      logic [31:0] cnt;
      logic [4:0]  a0;
      logic [2:0]  t0;
      logic [4:0]  a1;
      logic [2:0]  t1;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  x;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.N_STAGES(2), .WIDTH_T(3), .CNT_W(32)) bus ();

   hazard_scoreboard #(
      .N_STAGES(2), .WIDTH_T(3), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (bus)
   );

   function automatic stim_t idle();
      return '0;
   endfunction

   function automatic stim_t ins(input logic [4:0] rs, input logic [2:0] tr,
                                 input logic [4:0] rt, input logic [2:0] tt,
                                 input logic [4:0] wa, input logic [2:0] tn,
                                 input logic mu, input logic ms, input logic md);
      stim_t s;
      s = '0;
      s.valid = 1'b1; s.rs = rs; s.tuse_rs = tr; s.rt = rt; s.tuse_rt = tt;
      s.waddr = wa; s.tnew = tn; s.md_use = mu; s.md_start = ms; s.md_div = md;
      return s;
   endfunction

   function automatic exp_t ex(input logic st, input logic [1:0] c, input logic b,
                               input int n, input logic [4:0] a0, input logic [2:0] t0,
                               input logic [4:0] a1, input logic [2:0] t1);
      exp_t x;
      x.stall = st; x.cause = c; x.busy = b; x.cnt = n;
      x.a0 = a0; x.t0 = t0; x.a1 = a1; x.t1 = t1;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(input stim_t s);
      bus.id_valid    = s.valid;    bus.id_rs      = s.rs;      bus.id_rt     = s.rt;
      bus.id_tuse_rs  = s.tuse_rs;  bus.id_tuse_rt = s.tuse_rt; bus.id_waddr  = s.waddr;
      bus.id_tnew     = s.tnew;     bus.id_md_use  = s.md_use;  bus.id_md_start = s.md_start;
      bus.id_md_div   = s.md_div;   bus.freeze     = s.freeze;  bus.flush     = s.flush;
   endtask

   task automatic check_outputs(input string tag);
      exp_t x;
      if (exp_q.size() == 0) begin
         chk({tag, " queue_empty"}, 32'd1, 32'd0);
         return;
      end
      x = exp_q.pop_front();
      chk({tag, " stall_pc"},  32'(bus.stall_pc),    32'(x.stall));
      chk({tag, " stall_id"},  32'(bus.stall_id),    32'(x.stall));
      chk({tag, " clr_ex"},    32'(bus.clr_ex),      32'(x.stall));
      chk({tag, " cause"},     32'(bus.stall_cause), 32'(x.cause));
      chk({tag, " md_busy"},   32'(bus.md_busy),     32'(x.busy));
      chk({tag, " stall_cnt"}, bus.stall_cnt,        x.cnt);
      chk({tag, " sb0"}, 32'({bus.sb_addr_flat[4:0], bus.sb_tnew_flat[2:0]}), 32'({x.a0, x.t0}));
      chk({tag, " sb1"}, 32'({bus.sb_addr_flat[9:5], bus.sb_tnew_flat[5:3]}), 32'({x.a1, x.t1}));
   endtask

   // Drive mid-cycle, expect against the state left by the previous edge.
   task automatic run_vec(input string tag, input stim_t s, input exp_t x);
      @(negedge clk);
      drive(s);
      exp_q.push_back(x);
      #1;
      check_outputs(tag);
   endtask

   task automatic add(input stim_t s, input exp_t x);
      vec_t v;
      v.s = s;
      v.x = x;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      stim_t mfhi13;
      stim_t mfhi14;
      stim_t mfhi;

      mfhi13 = ins(5'd0, 3'd0, 5'd0, 3'd0, 5'd13, 3'd2, 1'b1, 1'b0, 1'b0);
      mfhi14 = ins(5'd0, 3'd0, 5'd0, 3'd0, 5'd14, 3'd2, 1'b1, 1'b0, 1'b0);
      mfhi   = ins(5'd0, 3'd0, 5'd0, 3'd0, 5'd0,  3'd0, 1'b1, 1'b0, 1'b0);

      // lw then add: one stall
      add(idle(), ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      add(ins(5'd2, 3'd1, 5'd0, 3'd0, 5'd1, 3'd3, 0, 0, 0), ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      add(ins(5'd1, 3'd1, 5'd3, 3'd1, 5'd4, 3'd2, 0, 0, 0), ex(1, 2'b01, 0, 0, 1, 2, 0, 0));
      add(ins(5'd1, 3'd1, 5'd3, 3'd1, 5'd4, 3'd2, 0, 0, 0), ex(0, 2'b00, 0, 1, 0, 0, 1, 1));
      add(idle(), ex(0, 2'b00, 0, 1, 4, 1, 0, 0));
      add(idle(), ex(0, 2'b00, 0, 1, 0, 0, 4, 0));
      // lw then beq: two stalls
      add(ins(5'd2, 3'd1, 5'd0, 3'd0, 5'd1, 3'd3, 0, 0, 0), ex(0, 2'b00, 0, 1, 0, 0, 0, 0));
      add(ins(5'd1, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0, 0, 0, 0), ex(1, 2'b01, 0, 1, 1, 2, 0, 0));
      add(ins(5'd1, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0, 0, 0, 0), ex(1, 2'b01, 0, 2, 0, 0, 1, 1));
      add(ins(5'd1, 3'd0, 5'd5, 3'd0, 5'd0, 3'd0, 0, 0, 0), ex(0, 2'b00, 0, 3, 0, 0, 0, 0));
      // $0 writes and sw rt with tuse 2
      add(ins(5'd7, 3'd1, 5'd8, 3'd1, 5'd0, 3'd2, 0, 0, 0), ex(0, 2'b00, 0, 3, 0, 0, 0, 0));
      add(ins(5'd0, 3'd0, 5'd0, 3'd0, 5'd9, 3'd2, 0, 0, 0), ex(0, 2'b00, 0, 3, 0, 1, 0, 0));
      add(ins(5'd10, 3'd1, 5'd9, 3'd2, 5'd0, 3'd0, 0, 0, 0), ex(0, 2'b00, 0, 3, 9, 1, 0, 0));
      add(idle(), ex(0, 2'b00, 0, 3, 0, 0, 9, 0));
      // mult then mfhi: stalls t+1..t+5
      add(ins(5'd11, 3'd1, 5'd12, 3'd1, 5'd0, 3'd0, 1, 1, 0), ex(0, 2'b00, 0, 3, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) add(mfhi13, ex(1, 2'b10, 1, 3 + i, 0, 0, 0, 0));
      add(mfhi13, ex(0, 2'b00, 0, 8, 0, 0, 0, 0));
      add(idle(), ex(0, 2'b00, 0, 8, 13, 1, 0, 0));
      // div then mfhi: stalls t+1..t+10
      add(ins(5'd11, 3'd1, 5'd12, 3'd1, 5'd0, 3'd0, 1, 1, 1), ex(0, 2'b00, 0, 8, 0, 0, 13, 0));
      for (int i = 0; i < 10; i++) add(mfhi14, ex(1, 2'b10, 1, 8 + i, 0, 0, 0, 0));
      add(mfhi14, ex(0, 2'b00, 0, 18, 0, 0, 0, 0));
      add(idle(), ex(0, 2'b00, 0, 18, 14, 1, 0, 0));
      // data and md stall together
      add(ins(5'd0, 3'd0, 5'd0, 3'd0, 5'd2, 3'd3, 0, 0, 0), ex(0, 2'b00, 0, 18, 0, 0, 14, 0));
      add(ins(5'd3, 3'd1, 5'd4, 3'd1, 5'd0, 3'd0, 1, 1, 1), ex(0, 2'b00, 0, 18, 2, 2, 0, 0));
      add(ins(5'd2, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 1, 0, 0), ex(1, 2'b11, 1, 18, 0, 0, 2, 1));
      add(mfhi, ex(1, 2'b10, 1, 19, 0, 0, 0, 0));
      add(mfhi, ex(1, 2'b10, 1, 20, 0, 0, 0, 0));

      drive(idle());
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].x);

      // reset mid-div (md_cnt = 7): outputs drop without a clock edge
      run_vec("pre_reset", mfhi, ex(1, 2'b10, 1, 21, 0, 0, 0, 0));
      rst_n = 1'b0;
      #1;
      exp_q.push_back(ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      check_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // flush after lw enters EX; a TUSE_INF reader in ID meanwhile
      run_vec("fl_idle", idle(), ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      run_vec("fl_lw", ins(5'd2, 3'd1, 5'd0, 3'd0, 5'd1, 3'd3, 0, 0, 0),
              ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      s = ins(5'd1, TUSE_INF, 5'd1, TUSE_INF, 5'd6, 3'd2, 0, 0, 0);
      s.flush = 1'b1;
      run_vec("fl_flush", s, ex(0, 2'b00, 0, 0, 1, 2, 0, 0));
      run_vec("fl_add", ins(5'd1, 3'd1, 5'd0, 3'd0, 5'd0, 3'd0, 0, 0, 0),
              ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      run_vec("fl_idle2", idle(), ex(0, 2'b00, 0, 0, 0, 0, 0, 0));

      // freeze for three cycles during a data stall
      run_vec("fz_lw", ins(5'd2, 3'd1, 5'd0, 3'd0, 5'd1, 3'd3, 0, 0, 0),
              ex(0, 2'b00, 0, 0, 0, 0, 0, 0));
      s = ins(5'd1, 3'd1, 5'd0, 3'd0, 5'd4, 3'd2, 0, 0, 0);
      s.freeze = 1'b1;
      for (int i = 0; i < 3; i++)
         run_vec($sformatf("fz_hold%0d", i), s, ex(1, 2'b01, 0, 0, 1, 2, 0, 0));
      s.freeze = 1'b0;
      run_vec("fz_release", s, ex(1, 2'b01, 0, 0, 1, 2, 0, 0));
      run_vec("fz_go", s, ex(0, 2'b00, 0, 1, 0, 0, 1, 1));

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
